alu_issue_ctrl: RTL and testbench

- Initiator side of the ALU interface. Accepts one operation request from the execute stage over a valid/ready handshake.
- Drives alu_ctrl, srcA and srcB onto the combinational ALU, waits a per-opcode settle latency, and samples the ALU result.
- Returns the result, with an error flag, over a second valid/ready handshake.
- Sits between the decode/execute control path and the ALU. The ALU is treated as purely combinational but possibly multi-cycle for MUL and DIV.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_op_decode.sv | 32 +++
 rtl/alu_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue controller:
//   alu_op_t       - ALU opcode encoding
//   ALU_NOP        - value driven on alu_ctrl when the ALU is not in use
//   lat_sel_t      - settle-latency class of an opcode (FAST / MUL / DIV)
//   issue_state_t  - issue controller FSM states
//   op_is_legal()  - true for every defined opcode
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_OP_ADD  = 5'd1,
        ALU_OP_SUB  = 5'd2,
        ALU_OP_MUL  = 5'd3,
        ALU_OP_MOVE = 5'd4,
        ALU_OP_DIV  = 5'd5,
        ALU_OP_LNUM = 5'd6,
        ALU_OP_AND  = 5'd9,
        ALU_OP_OR   = 5'd10,
        ALU_OP_XOR  = 5'd11,
        ALU_OP_NOT  = 5'd12
    } alu_op_t;

    localparam logic [4:0] ALU_NOP = 5'd0;

    typedef enum logic [1:0] {
        LAT_SEL_FAST = 2'd0,
        LAT_SEL_MUL  = 2'd1,
        LAT_SEL_DIV  = 2'd2
    } lat_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } issue_state_t;

    function automatic logic op_is_legal(input logic [4:0] op);
        logic legal;
        case (op)
            ALU_OP_ADD, ALU_OP_SUB, ALU_OP_MUL, ALU_OP_MOVE, ALU_OP_DIV,
            ALU_OP_LNUM, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR, ALU_OP_NOT:
                legal = 1'b1;
            default:
                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// ---------------------------------------------------------------------------
// alu_op_decode
// Combinational classification of an incoming request.
// Ports:
//   op          in  [4:0]  requested opcode
//   b           in  [31:0] operand B (only inspected for divide-by-zero)
//   legal       out        opcode is one of the defined operations
//   div_by_zero out        DIV requested with a zero divisor
//   lat_sel     out        settle-latency class of the opcode
// ---------------------------------------------------------------------------
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [31:0] b,
    output logic        legal,
    output logic        div_by_zero,
    output lat_sel_t    lat_sel
);

    always_comb begin
        legal       = op_is_legal(op);
        div_by_zero = (op == ALU_OP_DIV) && (b == 32'd0);
        lat_sel     = LAT_SEL_FAST;
        if (op == ALU_OP_MUL) begin
            lat_sel = LAT_SEL_MUL;
        end else if (op == ALU_OP_DIV) begin
            lat_sel = LAT_SEL_DIV;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Initiator side of the ALU interface. Accepts one request, drives the
// combinational ALU for an opcode-dependent number of settle cycles, samples
// the result and returns it (with an error flag) over a response handshake.
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   req_valid/req_ready         request handshake
//   req_op, req_a, req_b        opcode and operands
//   alu_ctrl, alu_srcA/B        registered drive to the ALU
//   alu_result                  ALU output, sampled after settling
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_err         sampled result; err = illegal op or div by 0
//   busy                        high whenever not IDLE
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int LAT_FAST = 1,
    parameter int LAT_MUL  = 2,
    parameter int LAT_DIV  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [4:0]  alu_ctrl,
    output logic [31:0] alu_srcA,
    output logic [31:0] alu_srcB,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic        busy
);

    localparam int MAX_FM  = (LAT_FAST > LAT_MUL) ? LAT_FAST : LAT_MUL;
    localparam int MAX_LAT = (MAX_FM > LAT_DIV) ? MAX_FM : LAT_DIV;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    issue_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       alu_ctrl_q, alu_ctrl_d;
    logic [31:0]      src_a_q, src_a_d;
    logic [31:0]      src_b_q, src_b_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic             dec_legal;
    logic             dec_div_by_zero;
    lat_sel_t         dec_lat_sel;
    logic [CNT_W-1:0] lat_m1;

    alu_op_decode u_decode (
        .op          (req_op),
        .b           (req_b),
        .legal       (dec_legal),
        .div_by_zero (dec_div_by_zero),
        .lat_sel     (dec_lat_sel)
    );

    // Counter preload is L-1 so that the sampling edge lands at accept + L.
    always_comb begin
        lat_m1 = CNT_W'(LAT_FAST - 1);
        case (dec_lat_sel)
            LAT_SEL_MUL: lat_m1 = CNT_W'(LAT_MUL - 1);
            LAT_SEL_DIV: lat_m1 = CNT_W'(LAT_DIV - 1);
            default:     lat_m1 = CNT_W'(LAT_FAST - 1);
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_ctrl_d   = alu_ctrl_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        rsp_valid_d  = rsp_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (dec_legal && !dec_div_by_zero) begin
                        alu_ctrl_d = req_op;
                        src_a_d    = req_a;
                        src_b_d    = req_b;
                        cnt_d      = lat_m1;
                        state_d    = ST_SETTLE;
                    end else begin
                        // Rejected ops never reach the ALU; answer at once.
                        rsp_result_d = 32'd0;
                        rsp_err_d    = 1'b1;
                        rsp_valid_d  = 1'b1;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    alu_ctrl_d   = ALU_NOP;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            alu_ctrl_q   <= ALU_NOP;
            src_a_q      <= 32'd0;
            src_b_q      <= 32'd0;
            rsp_result_q <= 32'd0;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_ctrl_q   <= alu_ctrl_d;
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign alu_ctrl   = alu_ctrl_q;
    assign alu_srcA   = src_a_q;
    assign alu_srcB   = src_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Drives alu_issue_ctrl against a behavioural combinational ALU and compares
// each response (value, error flag, latency, handshake behaviour) with values
// computed directly from the opcode rules.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int LF = 1;
    localparam int LM = 2;
    localparam int LD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_op = 5'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [4:0]  alu_ctrl;
    logic [31:0] alu_srcA;
    logic [31:0] alu_srcB;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.LAT_FAST(LF), .LAT_MUL(LM), .LAT_DIV(LD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_ctrl   (alu_ctrl),
        .alu_srcA   (alu_srcA),
        .alu_srcB   (alu_srcB),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    // Behavioural ALU semantics (MOVE passes A, LNUM passes B).
    function automatic logic [31:0] alu_model(input logic [4:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            5'd1:    return a + b;
            5'd2:    return a - b;
            5'd3:    return a * b;
            5'd4:    return a;
            5'd5:    return (b == 32'd0) ? 32'd0 : a / b;
            5'd6:    return b;
            5'd9:    return a & b;
            5'd10:   return a | b;
            5'd11:   return a ^ b;
            5'd12:   return ~a;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit op_legal(input logic [4:0] op);
        return op inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
                          5'd9, 5'd10, 5'd11, 5'd12};
    endfunction

    function automatic int op_latency(input logic [4:0] op);
        if (op == 5'd3) return LM;
        if (op == 5'd5) return LD;
        return LF;
    endfunction

    assign alu_result = alu_model(alu_ctrl, alu_srcA, alu_srcB);

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to completion. Called with the bench
    // one time unit after a rising edge and the DUT idle. hold = number of
    // cycles the response is back-pressured after it appears.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic        err;
        logic [31:0] exp;
        int          lat;
        int          cycles;
        err    = !op_legal(op) || (op == 5'd5 && b == 32'd0);
        exp    = err ? 32'd0 : alu_model(op, a, b);
        lat    = op_latency(op);
        cycles = 0;

        check("pre_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        // Operands were latched at accept; scramble the inputs.
        req_valid = 1'b0;
        req_op    = 5'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;

        if (err) begin
            check("err_ctrl_nop", 32'(alu_ctrl), 32'd0);
        end else begin
            check("acc_srcA", alu_srcA, a);
            check("acc_srcB", alu_srcB, b);
            while (!rsp_valid && cycles < 16) begin
                check("settle_ctrl", 32'(alu_ctrl), 32'(op));
                check("settle_req_ready", 32'(req_ready), 32'd0);
                check("settle_busy", 32'(busy), 32'd1);
                @(posedge clk); #1;
                cycles++;
            end
            check("latency", 32'(cycles), 32'(lat));
            check("hold_srcA", alu_srcA, a);
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_result", rsp_result, exp);
        check("rsp_err", 32'(rsp_err), 32'(err));
        check("rsp_ctrl_nop", 32'(alu_ctrl), 32'd0);

        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_op    = 5'd1;
            @(posedge clk); #1;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_result", rsp_result, exp);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("clear_valid", 32'(rsp_valid), 32'd0);
        check("clear_idle", 32'(busy), 32'd0);
        check("no_accept_same_edge", 32'(alu_ctrl), 32'd0);
        req_valid = 1'b0;
        $display("txn op=%0d a=0x%08h b=0x%08h hold=%0d -> result=0x%08h err=%0d lat=%0d",
                 op, a, b, hold, rsp_result, rsp_err, cycles);
    endtask

    logic [4:0] legal_ops [10] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5,
                                   5'd6, 5'd9, 5'd10, 5'd11, 5'd12};

    initial begin
        logic [4:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_ctrl", 32'(alu_ctrl), 32'd0);
        check("rst_srcA", alu_srcA, 32'd0);
        check("rst_srcB", alu_srcB, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op(5'd1, 32'd1, 32'd5, 0);           // ADD 1+5
        run_op(5'd5, 32'd16, 32'd4, 0);          // DIV 16/4
        run_op(5'd7, 32'd3, 32'd3, 0);           // illegal opcode
        run_op(5'd0, 32'd3, 32'd3, 1);           // NOP is illegal too
        run_op(5'd5, 32'd9, 32'd0, 0);           // divide by zero
        run_op(5'd3, 32'd2, 32'd8, 5);           // MUL with backpressure

        // Reset during DIV settle
        req_valid = 1'b1; req_op = 5'd5; req_a = 32'd100; req_b = 32'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_ctrl", 32'(alu_ctrl), 32'd0);
        check("mid_rst_srcA", alu_srcA, 32'd0);
        check("mid_rst_srcB", alu_srcB, 32'd0);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_result", rsp_result, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        $display("txn reset during DIV settle -> dropped");
        run_op(5'd1, 32'd2, 32'd1, 0);           // ADD 2+1 after reset

        // Back-to-back
        run_op(5'd2, 32'd2, 32'd1, 0);           // SUB
        run_op(5'd9, 32'd1, 32'd1, 0);           // AND
        run_op(5'd12, 32'd0, 32'd0, 0);          // NOT 0

        // Randomized
        for (int n = 0; n < 40; n++) begin
            r_op = legal_ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 6) == 0) begin
                r_op = 5'($urandom);
            end
            r_a = $urandom;
            r_b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (r_op == 5'd5 && r_b != 32'd0) begin
                r_b = r_b >> $urandom_range(0, 28);
            end
            run_op(r_op, r_a, r_b, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
